// File: rtl/pill_pkg.sv
// Shared definitions for the pill-filling hopper: FSM encoding, BCD count type,
// default timing constants and a BCD digit validity helper.
package pill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_FILL   = 3'd2,
        ST_SWITCH = 3'd3,
        ST_STARVE = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef logic [11:0] bcd3_t;

    localparam int unsigned SWITCH_CYC_DEF = 2000;
    localparam int unsigned STARVE_CYC_DEF = 5000;

    function automatic logic bcd3_valid(input bcd3_t v);
        return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd3_counter.sv
// Three-digit BCD pill counter with synchronous clear, increment (999 wraps to 000)
// and a flag telling whether the next increment lands on the target.
module bcd3_counter
    import pill_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clr_i,
    input  logic  inc_i,
    input  bcd3_t target_i,
    output bcd3_t count_o,
    output logic  hit_o
);

    bcd3_t count_q, count_d, inc_val;

    always_comb begin
        inc_val = count_q;
        if (count_q[3:0] != 4'd9) begin
            inc_val[3:0] = count_q[3:0] + 4'd1;
        end else begin
            inc_val[3:0] = '0;
            if (count_q[7:4] != 4'd9) begin
                inc_val[7:4] = count_q[7:4] + 4'd1;
            end else begin
                inc_val[7:4]  = '0;
                inc_val[11:8] = (count_q[11:8] == 4'd9) ? 4'd0 : count_q[11:8] + 4'd1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (clr_i)      count_d = '0;
        else if (inc_i) count_d = inc_val;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    // Independent of inc_i so the caller can gate it without a combinational loop.
    assign hit_o   = (inc_val == target_i);
    assign count_o = count_q;

endmodule

// File: rtl/hopper_arbiter.sv
// Round-robin arbiter sharing one pill hopper among N_ST bottle stations, with
// per-bottle BCD counting, bottle-change gap, starve detection and emergency stop.
module hopper_arbiter
    import pill_pkg::*;
#(
    parameter int unsigned N_ST       = 4,
    parameter int unsigned SWITCH_CYC = SWITCH_CYC_DEF,
    parameter int unsigned STARVE_CYC = STARVE_CYC_DEF
) (
    input  logic            clk_1khz,
    input  logic            clr,
    input  logic            start,
    input  logic            estop,
    input  logic            fault_ack,
    input  logic [11:0]     target_pills,
    input  logic            pill_pulse,
    input  logic [N_ST-1:0] req,
    output logic [N_ST-1:0] grant,
    output logic            gate_open,
    output logic [N_ST-1:0] bottle_done,
    output logic [N_ST-1:0] bottle_abort,
    output logic [11:0]     pill_count,
    output logic [2:0]      state,
    output logic            fault_starve
);

    localparam int unsigned TMAX = (SWITCH_CYC > STARVE_CYC) ? SWITCH_CYC : STARVE_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned IW   = (N_ST > 1) ? $clog2(N_ST) : 1;
    localparam logic [TW-1:0] SWITCH_LIM = TW'(SWITCH_CYC - 1);
    localparam logic [TW-1:0] STARVE_LIM = TW'(STARVE_CYC - 1);

    state_e          state_q, state_d;
    logic [N_ST-1:0] grant_q, grant_d;
    logic [N_ST-1:0] done_q, done_d;
    logic [N_ST-1:0] abort_q, abort_d;
    logic [IW-1:0]   last_q, last_d;
    logic [TW-1:0]   timer_q, timer_d;
    bcd3_t           target_q, target_d;

    logic            rr_found;
    logic [IW-1:0]   rr_idx;
    logic            cnt_clr, cnt_inc, cnt_hit;
    bcd3_t           count;

    bcd3_counter u_count (
        .clk_i   (clk_1khz),
        .rst_i   (clr),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .target_i(target_q),
        .count_o (count),
        .hit_o   (cnt_hit)
    );

    // First requester after the last granted index, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned k = 1; k <= N_ST; k++) begin
            if (!rr_found && req[IW'((32'(last_q) + k) % N_ST)]) begin
                rr_found = 1'b1;
                rr_idx   = IW'((32'(last_q) + k) % N_ST);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        timer_d  = timer_q;
        target_d = target_q;
        done_d   = '0;
        abort_d  = '0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        if (estop) begin
            state_d = ST_HALT;
            grant_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && bcd3_valid(target_pills) && (target_pills != '0)) begin
                        target_d = target_pills;
                        state_d  = ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (rr_found) begin
                        grant_d         = '0;
                        grant_d[rr_idx] = 1'b1;
                        last_d          = rr_idx;
                        cnt_clr         = 1'b1;
                        timer_d         = '0;
                        state_d         = ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt_inc = pill_pulse;
                    if (!req[last_q]) begin
                        abort_d[last_q] = 1'b1;
                        grant_d         = '0;
                        timer_d         = '0;
                        state_d         = ST_SWITCH;
                    end else if (pill_pulse && cnt_hit) begin
                        done_d[last_q] = 1'b1;
                        grant_d        = '0;
                        timer_d        = '0;
                        state_d        = ST_SWITCH;
                    end else if (pill_pulse) begin
                        timer_d = '0;
                    end else if (timer_q == STARVE_LIM) begin
                        state_d = ST_STARVE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_SWITCH: begin
                    if (timer_q == SWITCH_LIM) begin
                        timer_d = '0;
                        cnt_clr = 1'b1;
                        state_d = ST_ARB;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_STARVE: begin
                    if (fault_ack) begin
                        timer_d = '0;
                        state_d = ST_FILL;
                    end
                end
                ST_HALT: begin
                    if (fault_ack) begin
                        cnt_clr = 1'b1;
                        last_d  = IW'(N_ST - 1);
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1khz or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            last_q   <= IW'(N_ST - 1);
            timer_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            target_q <= target_d;
        end
    end

    assign grant        = grant_q;
    assign gate_open    = (state_q == ST_FILL);
    assign bottle_done  = done_q;
    assign bottle_abort = abort_q;
    assign pill_count   = count;
    assign state        = state_q;
    assign fault_starve = (state_q == ST_STARVE);

endmodule

// File: doc/hopper_arbiter.md
HOPPER_ARBITER -- requirements
Module: hopper_arbiter

Interface
REQ-001 Parameter N_ST, default 4, number of filling stations sharing the single hopper.
REQ-002 Parameter SWITCH_CYC, default 2000, bottle-change gap in clock cycles (2 s at 1 kHz).
REQ-003 Parameter STARVE_CYC, default 5000, cycles without a pill pulse before a starve fault.
REQ-004 clk_1khz  in  1  sole clock; all logic on rising edge.
REQ-005 clr  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; arms the block from IDLE.
REQ-007 estop  in  1  level; emergency stop, highest priority.
REQ-008 fault_ack  in  1  one-cycle pulse; clears STARVE or HALT.
REQ-009 target_pills  in  12  three BCD digits (hundreds, tens, ones), pills per bottle.
REQ-010 pill_pulse  in  1  one-cycle pulse per pill dropped by the hopper (already edge-detected).
REQ-011 req  in  N_ST  level; station i has a bottle in place and wants fill.
REQ-012 grant  out  N_ST  one-hot or zero; station owning the hopper.
REQ-013 gate_open  out  1  hopper gate enable.
REQ-014 bottle_done  out  N_ST  one-cycle pulse, bottle of station i reached target.
REQ-015 bottle_abort  out  N_ST  one-cycle pulse, station i withdrew its request mid-fill.
REQ-016 pill_count  out  12  BCD count for the current bottle.
REQ-017 state  out  3  encoded FSM state for the display.
REQ-018 fault_starve  out  1  high in STARVE.

Function
REQ-019 States SHALL be IDLE=0, ARB=1, FILL=2, SWITCH=3, STARVE=4, HALT=5.
REQ-020 IDLE: start with all target digits <=9 and target !=000 SHALL latch target_pills internally and go to ARB; otherwise start is ignored.
REQ-021 ARB: grant SHALL go round-robin, searching from (last granted index + 1) mod N_ST. The winner is registered and FILL is entered on the next cycle with pill_count=000. No requester means the block stays in ARB.
REQ-022 FILL: gate_open=1 and grant is one-hot. Each pill_pulse increments pill_count in BCD, with 9 carrying into the next digit and 999 wrapping to 000.
REQ-023 FILL: the pill_pulse that makes the count equal the latched target SHALL pulse bottle_done[g] in the same cycle as the count update, then enter SWITCH.
REQ-024 FILL: req[g] low SHALL pulse bottle_abort[g] and go to SWITCH. A pill_pulse in that same cycle is counted but bottle_done is not pulsed.
REQ-025 FILL: the starve counter reloads on every pill_pulse and on entry. Reaching STARVE_CYC gives STARVE. A pill_pulse in the expiry cycle wins, and the block stays in FILL.
REQ-026 SWITCH: gate_open=0 and grant=0. pill_pulse is ignored. After exactly SWITCH_CYC cycles the block goes to ARB with pill_count cleared.
REQ-027 STARVE: gate_open=0, grant held, fault_starve=1, pill_count held. fault_ack SHALL return to FILL with the starve counter reloaded.
REQ-028 estop high in any state SHALL force HALT on the next edge: gate_open=0, grant=0, pill_count held.
REQ-029 HALT: with estop low, fault_ack SHALL go to IDLE and clear pill_count and last-grant. fault_ack while estop is high is ignored.
REQ-030 Priority within a cycle SHALL be estop > done/abort > starve expiry > other transitions.
REQ-031 target_pills changes after start SHALL have no effect until the next IDLE->ARB transition.

Reset
REQ-032 clr SHALL asynchronously force state=IDLE, grant=0, gate_open=0, bottle_done=0, bottle_abort=0, pill_count=000, fault_starve=0, timers=0, last-grant=N_ST-1 (so station 0 wins first), latched target=000.
REQ-033 clr asserted mid-FILL SHALL close the gate in the same instant, without waiting for a clock edge.

Structure
REQ-034 Shared package pill_pkg SHALL hold the state encoding, the 12-bit BCD type, and the default SWITCH_CYC and STARVE_CYC values, for reuse by the display logic.
REQ-035 A sub-module bcd3_counter SHALL implement the clear, increment and compare-equal functions of the three-digit BCD counter.
REQ-036 Timers SHALL be sized clog2(max(SWITCH_CYC, STARVE_CYC)+1) bits.

Verification
REQ-037 Scenario 1 (basic fill): target=003, req=0001, start, then 3 pill pulses -> bottle_done[0] on the 3rd pulse, gate_open low, ARB exactly 2000 cycles later.
REQ-038 Scenario 2 (round-robin): target=002, req=1111 held, four bottles filled -> grant order 0,1,2,3, then 0 again.
REQ-039 Scenario 3 (starve and recovery): in FILL, no pulse for 5000 cycles -> STARVE, fault_starve=1, count held. fault_ack -> FILL, and the count resumes from the held value.
REQ-040 Scenario 4 (BCD carry): target=100, 99 pulses -> pill_count=099. 100th pulse -> pill_count=100 and bottle_done asserted.
REQ-041 Scenario 5 (emergency stop): estop mid-FILL -> HALT next edge with grant=0. fault_ack while estop is high -> no change. estop low then fault_ack -> IDLE with count 000.
REQ-042 Scenario 6 (abort collision): req[g] drops in the same cycle as the target-reaching pulse -> bottle_abort only, no bottle_done, then SWITCH. Also: clr mid-SWITCH -> all outputs at reset values immediately.
